pma_pipe_arbiter: RTL and testbench

- Shares one in-order, fixed-depth pipelined datapath (shift-buffer stage chain with stall input) among P_REQ requesters.
- Round-robin selects one request per cycle and issues it to the pipeline.
- Stores the requester ID of each in-flight item in a tag FIFO, steers each retiring result back to its owner, and drives the pipeline stall when the owner is not ready.
- Sits between the PMA requester ports and the datapath pipeline.

---
 rtl/pma_pipe_arbiter_if.sv | 36 +++
 rtl/pma_pipe_arbiter.sv | 156 +++++++++++++++
 tb/tb_pma_pipe_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pma_pipe_arbiter_if.sv
// pma_pipe_arbiter_if
//   Bundles the requester handshake, pipeline issue/retire bus and the
//   result return bus of pma_pipe_arbiter. The arbiter connects through the
//   slave modport; the requesters plus pipeline (or a bench) use master.
interface pma_pipe_arbiter_if #(
  parameter int P_REQ   = 4,
  parameter int P_WIDTH = 32
);
  // requester side
  logic [P_REQ-1:0]         i_req;
  logic [P_REQ*P_WIDTH-1:0] i_req_data;
  logic [P_REQ-1:0]         o_req_ack;
  // pipeline issue side
  logic [P_WIDTH-1:0]       o_pipe_in;
  logic                     o_pipe_in_valid;
  logic                     o_pipe_stall;
  // pipeline retire side
  logic [P_WIDTH-1:0]       i_pipe_out;
  logic                     i_pipe_out_valid;
  // result return side
  logic [P_REQ-1:0]         o_rsp_valid;
  logic [P_WIDTH-1:0]       o_rsp_data;
  logic [P_REQ-1:0]         i_rsp_ready;

  modport slave (
    input  i_req, i_req_data, i_pipe_out, i_pipe_out_valid, i_rsp_ready,
    output o_req_ack, o_pipe_in, o_pipe_in_valid, o_pipe_stall,
           o_rsp_valid, o_rsp_data
  );

  modport master (
    output i_req, i_req_data, i_pipe_out, i_pipe_out_valid, i_rsp_ready,
    input  o_req_ack, o_pipe_in, o_pipe_in_valid, o_pipe_stall,
           o_rsp_valid, o_rsp_data
  );
endinterface

// File: rtl/pma_pipe_arbiter.sv
// pma_pipe_arbiter
//   Shares one in-order, fixed-depth pipeline among P_REQ requesters.
//   A round-robin arbiter issues at most one request per cycle, the owner ID
//   of every in-flight item is queued in a tag FIFO, and each retiring result
//   is steered back to the requester at the FIFO head. If that owner is not
//   ready the whole pipeline is stalled, so results never overtake each other.
//
//   Optional build macro: PMA_PIPE_ARB_PERF_EN adds saturating 32-bit
//   o_issue_cnt / o_stall_cnt performance counters.
module pma_pipe_arbiter #(
  parameter int P_REQ    = 4,
  parameter int P_WIDTH  = 32,
  parameter int P_STAGES = 6
) (
  input  logic i_clk,
  input  logic i_rst_n,
  pma_pipe_arbiter_if.slave bus
`ifdef PMA_PIPE_ARB_PERF_EN
  ,
  output logic [31:0] o_issue_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int TAG_W = (P_REQ > 1) ? $clog2(P_REQ) : 1;
  localparam int PTR_W = (P_STAGES > 1) ? $clog2(P_STAGES) : 1;
  localparam int CNT_W = $clog2(P_STAGES + 1);

  // Registered state
  logic [TAG_W-1:0] tag_mem [P_STAGES];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] inflight;
  logic [TAG_W-1:0] rr_ptr;

  // Combinational decisions
  logic [TAG_W-1:0]   head;
  logic               out_valid;
  logic               stall;
  logic               retire;
  logic               found;
  logic [TAG_W-1:0]   grant_idx;
  logic               issue_ok;
  logic               issue;
  logic [P_REQ-1:0]   req_ack;
  logic [P_WIDTH-1:0] pipe_in;
  logic [P_REQ-1:0]   rsp_valid;
  logic [P_WIDTH-1:0] rsp_data;

  // Pointer increment that wraps at P_STAGES (depth need not be a power of 2)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(P_STAGES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Retire side: steer the pipeline result to the owner at the FIFO head.
  // A result arriving with nothing in flight is a protocol error and is
  // ignored. Everything is gated by reset so outputs drop asynchronously.
  // NOTE: every signal assigned in an always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    head      = tag_mem[rd_ptr];
    out_valid = 1'b0;
    stall     = 1'b0;
    retire    = 1'b0;
    rsp_valid = '0;
    rsp_data  = '0;
    if (i_rst_n && bus.i_pipe_out_valid && (inflight != '0)) begin
      out_valid       = 1'b1;
      rsp_valid[head] = 1'b1;
      rsp_data        = bus.i_pipe_out;
      stall           = !bus.i_rsp_ready[head];
      retire          = bus.i_rsp_ready[head];
    end
  end

  // Round-robin search: first set request at or after rr_ptr, wrapping
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < P_REQ; k++) begin
      if (!found && bus.i_req[(int'(rr_ptr) + k) % P_REQ]) begin
        found     = 1'b1;
        grant_idx = TAG_W'((int'(rr_ptr) + k) % P_REQ);
      end
    end
  end

  // Issue side: grant only with a free slot and no stall; a retire in the
  // same cycle does not free a slot until the next cycle.
  always_comb begin
    issue_ok = i_rst_n && (inflight < CNT_W'(P_STAGES)) && !stall;
    issue    = found && issue_ok;
    req_ack  = '0;
    pipe_in  = '0;
    if (issue) begin
      req_ack[grant_idx] = 1'b1;
      pipe_in            = bus.i_req_data[int'(grant_idx)*P_WIDTH +: P_WIDTH];
    end
  end

  assign bus.o_req_ack       = req_ack;
  assign bus.o_pipe_in       = pipe_in;
  assign bus.o_pipe_in_valid = issue;
  assign bus.o_pipe_stall    = stall;
  assign bus.o_rsp_valid     = rsp_valid;
  assign bus.o_rsp_data      = rsp_data;

  // Tag storage: write the granted owner at the write pointer on issue
  // NOTE: the tag array is not reset; an entry is only read once inflight shows it was written.
  always_ff @(posedge i_clk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  // Control state: FIFO pointers, inflight count and round-robin pointer
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
      rr_ptr   <= '0;
    end else begin
      if (issue) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rr_ptr <= (grant_idx == TAG_W'(P_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
      end
      if (retire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({issue, retire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef PMA_PIPE_ARB_PERF_EN
  // Saturating counters of issues and of stalled cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_issue_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (issue && (o_issue_cnt != '1)) begin
        o_issue_cnt <= o_issue_cnt + 32'd1;
      end
      if (stall && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pma_pipe_arbiter.sv
// tb_pma_pipe_arbiter
//   Drives pma_pipe_arbiter with directed and random traffic against a
//   6-stage stallable pipeline model. Expected grants, stalls and responses
//   come from a queue-based reference of the arbitration/ordering rules.
//   Define PMA_PIPE_ARB_PERF_EN to also check the performance counters.
module tb_pma_pipe_arbiter;
  localparam int P_REQ    = 4;
  localparam int P_WIDTH  = 32;
  localparam int P_STAGES = 6;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  pma_pipe_arbiter_if #(.P_REQ(P_REQ), .P_WIDTH(P_WIDTH)) bus ();

`ifdef PMA_PIPE_ARB_PERF_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  pma_pipe_arbiter #(.P_REQ(P_REQ), .P_WIDTH(P_WIDTH), .P_STAGES(P_STAGES)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
`ifdef PMA_PIPE_ARB_PERF_EN
    ,
    .o_issue_cnt (issue_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  // Reference: outstanding items in issue order
  typedef struct {
    int                 owner;
    logic [P_WIDTH-1:0] result;
  } item_t;

  item_t              exp_q[$];
  int                 rr_ptr_m;
  int                 n_issue_m;
  int                 n_stall_m;
  logic               pipe_v [P_STAGES];
  logic [P_WIDTH-1:0] pipe_d [P_STAGES];

  int errors = 0;
  int checks = 0;

  // Last observed DUT outputs, for scenario-level checks
  logic [P_REQ-1:0]   last_ack;
  logic               last_stall;
  logic [P_REQ-1:0]   last_rsp_valid;
  logic [P_WIDTH-1:0] last_rsp_data;

  // Datapath function computed by the pipeline model
  function automatic logic [P_WIDTH-1:0] xform(input logic [P_WIDTH-1:0] x);
    return {x[P_WIDTH/2-1:0], x[P_WIDTH-1:P_WIDTH/2]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    rr_ptr_m  = 0;
    n_issue_m = 0;
    n_stall_m = 0;
    for (int s = 0; s < P_STAGES; s++) begin
      pipe_v[s] = 1'b0;
      pipe_d[s] = '0;
    end
  endtask

  // One clock cycle: drive inputs, compare against the reference, advance
  task automatic step(input logic [P_REQ-1:0] req, input logic [P_REQ-1:0] ready,
                      input bit force_pv = 1'b0);
    logic [P_REQ-1:0]   e_ack;
    logic [P_REQ-1:0]   e_rv;
    logic [P_WIDTH-1:0] e_rd;
    logic [P_WIDTH-1:0] e_pin;
    logic               e_stall;
    logic               head_ok;
    logic               d_piv;
    logic [P_WIDTH-1:0] d_pin;
    logic               d_stall;
    int                 g;
    @(negedge i_clk);
    bus.i_req       = req;
    bus.i_rsp_ready = ready;
    for (int k = 0; k < P_REQ; k++) bus.i_req_data[k*P_WIDTH +: P_WIDTH] = $urandom;
    bus.i_pipe_out_valid = pipe_v[P_STAGES-1] | force_pv;
    bus.i_pipe_out       = pipe_d[P_STAGES-1];
    #1;
    // Retire expectation
    head_ok = bus.i_pipe_out_valid && (exp_q.size() > 0);
    e_rv    = '0;
    e_rd    = '0;
    e_stall = 1'b0;
    if (head_ok) begin
      e_rv[exp_q[0].owner] = 1'b1;
      e_rd    = bus.i_pipe_out;
      e_stall = !ready[exp_q[0].owner];
    end
    if (pipe_v[P_STAGES-1] && (exp_q.size() > 0))
      check("result_order", bus.i_pipe_out, exp_q[0].result);
    // Grant expectation
    g = -1;
    if ((exp_q.size() < P_STAGES) && !e_stall)
      for (int k = 0; k < P_REQ; k++)
        if ((g < 0) && req[(rr_ptr_m + k) % P_REQ]) g = (rr_ptr_m + k) % P_REQ;
    e_ack = '0;
    e_pin = '0;
    if (g >= 0) begin
      e_ack[g] = 1'b1;
      e_pin    = bus.i_req_data[g*P_WIDTH +: P_WIDTH];
    end
    check("req_ack",       bus.o_req_ack,       e_ack);
    check("pipe_in_valid", bus.o_pipe_in_valid, g >= 0);
    check("pipe_in",       bus.o_pipe_in,       e_pin);
    check("pipe_stall",    bus.o_pipe_stall,    e_stall);
    check("rsp_valid",     bus.o_rsp_valid,     e_rv);
    check("rsp_data",      bus.o_rsp_data,      e_rd);
    last_ack       = bus.o_req_ack;
    last_stall     = bus.o_pipe_stall;
    last_rsp_valid = bus.o_rsp_valid;
    last_rsp_data  = bus.o_rsp_data;
    d_piv   = bus.o_pipe_in_valid;
    d_pin   = bus.o_pipe_in;
    d_stall = bus.o_pipe_stall;
    @(posedge i_clk);
    #1;
    if (head_ok && !e_stall) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back('{owner: g, result: xform(e_pin)});
      rr_ptr_m = (g + 1) % P_REQ;
      n_issue_m++;
    end
    if (e_stall) n_stall_m++;
    if (!d_stall) begin
      for (int s = P_STAGES - 1; s > 0; s--) begin
        pipe_v[s] = pipe_v[s-1];
        pipe_d[s] = pipe_d[s-1];
      end
      pipe_v[0] = d_piv;
      pipe_d[0] = d_piv ? xform(d_pin) : '0;
    end
  endtask

  // Asynchronous reset mid-cycle with all requests asserted
  task automatic do_reset();
    @(negedge i_clk);
    #2;
    bus.i_req       = '1;
    bus.i_rsp_ready = '1;
    i_rst_n         = 1'b0;
    #1;
    check("rst_req_ack",       bus.o_req_ack,       '0);
    check("rst_pipe_in_valid", bus.o_pipe_in_valid, 1'b0);
    check("rst_pipe_stall",    bus.o_pipe_stall,    1'b0);
    check("rst_rsp_valid",     bus.o_rsp_valid,     '0);
    check("rst_pipe_in",       bus.o_pipe_in,       '0);
    check("rst_rsp_data",      bus.o_rsp_data,      '0);
    clear_model();
    bus.i_pipe_out_valid = 1'b0;
    bus.i_pipe_out       = '0;
`ifdef PMA_PIPE_ARB_PERF_EN
    check("rst_issue_cnt", issue_cnt, '0);
    check("rst_stall_cnt", stall_cnt, '0);
`endif
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    bus.i_req = '0;
    i_rst_n   = 1'b1;
  endtask

  function automatic logic [P_REQ-1:0] rand_ready();
    logic [P_REQ-1:0] r;
    for (int k = 0; k < P_REQ; k++) r[k] = ($urandom_range(0, 9) < 8);
    return r;
  endfunction

  initial begin
    int                 cnt;
    int                 bp_seen;
    logic [P_WIDTH-1:0] bp_data;
    logic [P_REQ-1:0]   rdy;

    bus.i_req            = '1;
    bus.i_req_data       = '0;
    bus.i_rsp_ready      = '1;
    bus.i_pipe_out       = '0;
    bus.i_pipe_out_valid = 1'b0;
    clear_model();
    do_reset();

    // Round-robin with everyone requesting and always ready
    step('1, '1);
    check("first_grant", last_ack, 4'b0001);
    step('1, '1);
    check("rr_grant_1", last_ack, 4'b0010);
    step('1, '1);
    check("rr_grant_2", last_ack, 4'b0100);
    step('1, '1);
    check("rr_grant_3", last_ack, 4'b1000);
    repeat (20) step('1, '1);

    // Backpressure: hold requester 2's result at the head for 3 cycles
    bp_seen = 0;
    bp_data = '0;
    for (int i = 0; i < 60; i++) begin
      rdy = '1;
      if ((bp_seen < 3) && pipe_v[P_STAGES-1] && (exp_q.size() > 0) && (exp_q[0].owner == 2))
        rdy[2] = 1'b0;
      step('1, rdy);
      if (!rdy[2]) begin
        check("bp_no_grant", last_ack, '0);
        if (bp_seen == 0) bp_data = last_rsp_data;
        else check("bp_data_stable", last_rsp_data, bp_data);
        if (last_stall) bp_seen++;
      end
    end
    check("bp_stall_cycles", bp_seen, 3);

    // Full: drain, then 6 issues with nobody ready
    repeat (8) step('0, '1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step('1, '0);
      if (last_ack != '0) cnt++;
    end
    check("full_grants", cnt, 6);
    step('1, '1);
    check("full_retire_no_grant", last_ack, '0);
    step('1, '1);
    check("full_grant_after_retire", last_ack != '0, 1'b1);

    // Protocol error: result valid with nothing in flight
    repeat (10) step('0, '1);
    step('0, '1, 1'b1);
    check("proto_rsp_valid", last_rsp_valid, '0);
    check("proto_stall", last_stall, 1'b0);
    step('0, '1);

    // Random traffic: mixed issue/retire, FIFO wrap, ordering
    repeat (400) step(P_REQ'($urandom), rand_ready());
    repeat (12) step('0, '1);

`ifdef PMA_PIPE_ARB_PERF_EN
    check("perf_issue_cnt", issue_cnt, n_issue_m);
    check("perf_stall_cnt", stall_cnt, n_stall_m);
`endif

    // Reset in the middle of traffic, then resume
    repeat (10) step(P_REQ'($urandom), rand_ready());
    do_reset();
    step('1, '1);
    check("post_reset_first_grant", last_ack, 4'b0001);
    repeat (40) step(P_REQ'($urandom), rand_ready());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
